// File: rtl/ysyx_24080006_stream_fifo.sv
// rtl/ysyx_24080006_stream_fifo.sv - valid/ready stream FIFO with optional empty bypass
module ysyx_24080006_stream_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int AF_LEVEL     = FIFO_DEPTH - 1,
  parameter int AE_LEVEL     = 1,
  parameter int FALL_THROUGH = 0,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      usage,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Storage is never cleared; validity is tracked purely by usage_q.
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] usage_q, usage_d;

  logic empty;
  logic full;
  logic bypass_path;
  logic push_fire;
  logic pop_fire;
  logic bypass;
  logic store;
  logic take;

  // Handshake qualification; when empty with fall-through the producer is wired to the consumer.
  always_comb begin
    empty       = (usage_q == '0);
    full        = (usage_q == FULL_CNT);
    bypass_path = (FALL_THROUGH != 0) && empty;
    push_ready  = ~full & ~reset & ~flush;
    if (bypass_path) begin
      pop_valid = push_valid & ~reset & ~flush;
    end else begin
      pop_valid = ~empty & ~reset & ~flush;
    end
    pop_data  = bypass_path ? push_data : mem_q[rd_ptr_q];
    push_fire = push_valid & push_ready;
    pop_fire  = pop_valid & pop_ready;
    bypass    = bypass_path & push_fire & pop_fire;
    store     = push_fire & ~bypass;
    take      = pop_fire & ~bypass;
  end

  // Next pointers and occupancy; pointers wrap by compare so any depth works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (store) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (take) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({store, take})
        2'b10:   usage_d = usage_q + CNT_W'(1);
        2'b01:   usage_d = usage_q - CNT_W'(1);
        default: usage_d = usage_q;
      endcase
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Payload storage, written only for words that do not bypass.
  always_ff @(posedge clock) begin
    if (store) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Status flags come from registered occupancy only.
  always_comb begin
    usage        = usage_q;
    almost_full  = (int'(usage_q) >= AF_LEVEL);
    almost_empty = (int'(usage_q) <= AE_LEVEL);
  end

endmodule

// File: tb/tb_ysyx_24080006_stream_fifo.sv
// tb/tb_ysyx_24080006_stream_fifo.sv - self-checking bench for the stream FIFO
module tb_ysyx_24080006_stream_fifo;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int CW = $clog2(D + 1);

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic         push_valid;
  logic [W-1:0] push_data;
  logic         pop_ready;

  logic          push_ready0, pop_valid0, af0, ae0;
  logic [W-1:0]  pop_data0;
  logic [CW-1:0] usage0;
  logic          push_ready1, pop_valid1, af1, ae1;
  logic [W-1:0]  pop_data1;
  logic [CW-1:0] usage1;

  always #5 clock = ~clock;

  ysyx_24080006_stream_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready0), .push_data(push_data),
    .pop_valid(pop_valid0), .pop_ready(pop_ready), .pop_data(pop_data0),
    .usage(usage0), .almost_full(af0), .almost_empty(ae0)
  );

  ysyx_24080006_stream_fifo #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .FALL_THROUGH(1)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_ready(push_ready1), .push_data(push_data),
    .pop_valid(pop_valid1), .pop_ready(pop_ready), .pop_data(pop_data1),
    .usage(usage1), .almost_full(af1), .almost_empty(ae1)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  typedef struct {
    bit           rst, fl, pv;
    logic [W-1:0] pd;
    bit           pr;
    int           us;
    bit           prdy, pvld;
    logic [W-1:0] dat;
    bit           af, ae;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit rst, bit fl, bit pv, logic [W-1:0] pd, bit pr,
                             int us, bit prdy, bit pvld, logic [W-1:0] dat, bit af, bit ae);
    vec_t r;
    r.rst = rst; r.fl = fl; r.pv = pv; r.pd = pd; r.pr = pr;
    r.us = us; r.prdy = prdy; r.pvld = pvld; r.dat = dat; r.af = af; r.ae = ae;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of stored words; a FIFO of D entries with optional bypass when empty.
  task automatic check_model(input bit ft, input int size, input logic [W-1:0] head,
                             input logic pr_o, input logic pv_o, input logic [W-1:0] pd_o,
                             input logic [CW-1:0] us_o, input logic af_o, input logic ae_o,
                             input string tag);
    bit e_pr, e_pv;
    e_pr = !reset && !flush && (size < D);
    e_pv = !reset && !flush && ((size > 0) || (ft && push_valid));
    chk({tag, ".push_ready"}, pr_o, e_pr);
    chk({tag, ".pop_valid"}, pv_o, e_pv);
    if (e_pv) chk({tag, ".pop_data"}, pd_o, (size > 0) ? head : push_data);
    chk({tag, ".usage"}, us_o, size);
    chk({tag, ".almost_full"}, af_o, size >= D - 1);
    chk({tag, ".almost_empty"}, ae_o, size <= 1);
  endtask

  function automatic bit [1:0] model_act(input bit ft, input int size);
    bit pr, pv, pushf, popf;
    pr    = !reset && !flush && (size < D);
    pv    = !reset && !flush && ((size > 0) || (ft && push_valid));
    pushf = push_valid && pr;
    popf  = pv && pop_ready;
    if (ft && size == 0 && pushf && popf) return 2'b00;
    return {pushf, popf};
  endfunction

  // Called at the negedge: compare both DUTs with the model, then advance the model at the edge.
  task automatic finish_cycle();
    bit [1:0] a0, a1;
    check_model(1'b0, q0.size(), (q0.size() > 0) ? q0[0] : '0,
                push_ready0, pop_valid0, pop_data0, usage0, af0, ae0, "m0");
    check_model(1'b1, q1.size(), (q1.size() > 0) ? q1[0] : '0,
                push_ready1, pop_valid1, pop_data1, usage1, af1, ae1, "m1");
    a0 = model_act(1'b0, q0.size());
    a1 = model_act(1'b1, q1.size());
    @(posedge clock);
    if (reset || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (a0[0]) void'(q0.pop_front());
      if (a0[1]) q0.push_back(push_data);
      if (a1[0]) void'(q1.pop_front());
      if (a1[1]) q1.push_back(push_data);
    end
    #1;
  endtask

  task automatic cycle();
    @(negedge clock);
    finish_cycle();
  endtask

  task automatic drive(input bit rst, input bit fl, input bit pv, input logic [W-1:0] pd, input bit pr);
    reset = rst; flush = fl; push_valid = pv; push_data = pd; pop_ready = pr;
  endtask

  initial begin
    drive(1, 0, 0, 8'h00, 0);

    // Fill/drain order, push blocked when full, flush priority, reset mid-transfer (FT=0 instance).
    tbl.push_back(v(1,0,0,8'h00,0, 0,0,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'h11,0, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'h22,0, 1,1,1,8'h11,0,1));
    tbl.push_back(v(0,0,1,8'h33,0, 2,1,1,8'h11,1,0));
    tbl.push_back(v(0,0,1,8'h44,0, 3,0,1,8'h11,1,0));
    tbl.push_back(v(0,0,1,8'h44,1, 3,0,1,8'h11,1,0));
    tbl.push_back(v(0,0,0,8'h00,1, 2,1,1,8'h22,1,0));
    tbl.push_back(v(0,0,0,8'h00,1, 1,1,1,8'h33,0,1));
    tbl.push_back(v(0,0,0,8'h00,1, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'hA1,0, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'hA2,0, 1,1,1,8'hA1,0,1));
    tbl.push_back(v(0,1,1,8'hA3,1, 2,0,0,8'h00,1,0));
    tbl.push_back(v(0,0,0,8'h00,0, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'h55,0, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,1,8'h66,0, 1,1,1,8'h55,0,1));
    tbl.push_back(v(1,0,1,8'h99,1, 2,0,0,8'h00,1,0));
    tbl.push_back(v(0,0,1,8'h77,0, 0,1,0,8'h00,0,1));
    tbl.push_back(v(0,0,0,8'h00,1, 1,1,1,8'h77,0,1));
    tbl.push_back(v(0,0,0,8'h00,0, 0,1,0,8'h00,0,1));

    @(posedge clock);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].pv, tbl[i].pd, tbl[i].pr);
      @(negedge clock);
      chk($sformatf("tbl%0d.usage", i), usage0, tbl[i].us);
      chk($sformatf("tbl%0d.push_ready", i), push_ready0, tbl[i].prdy);
      chk($sformatf("tbl%0d.pop_valid", i), pop_valid0, tbl[i].pvld);
      if (tbl[i].pvld) chk($sformatf("tbl%0d.pop_data", i), pop_data0, tbl[i].dat);
      chk($sformatf("tbl%0d.almost_full", i), af0, tbl[i].af);
      chk($sformatf("tbl%0d.almost_empty", i), ae0, tbl[i].ae);
      finish_cycle();
    end

    // Steady push+pop at usage 2 across pointer wrap.
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'h01, 0); cycle();
    drive(0, 0, 1, 8'h02, 0); cycle();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, 8'(i + 3), 1);
      @(negedge clock);
      chk($sformatf("stream%0d.usage0", i), usage0, 2);
      chk($sformatf("stream%0d.data0", i), pop_data0, i + 1);
      chk($sformatf("stream%0d.data1", i), pop_data1, i + 1);
      finish_cycle();
    end

    // Fall-through bypass while empty.
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'hA5, 1);
    @(negedge clock);
    chk("bypass.pop_valid1", pop_valid1, 1);
    chk("bypass.pop_data1", pop_data1, 8'hA5);
    chk("bypass.pop_valid0", pop_valid0, 0);
    finish_cycle();
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clock);
    chk("bypass.usage1_after", usage1, 0);
    chk("bypass.usage0_after", usage0, 1);
    finish_cycle();

    // Fall-through push without pop stores the word.
    drive(1, 0, 0, 8'h00, 0); cycle();
    drive(0, 0, 1, 8'h5A, 0); cycle();
    drive(0, 0, 0, 8'h00, 0);
    @(negedge clock);
    chk("ftstore.usage1", usage1, 1);
    chk("ftstore.pop_valid1", pop_valid1, 1);
    chk("ftstore.pop_data1", pop_data1, 8'h5A);
    finish_cycle();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 29) == 0),
            $urandom_range(0, 1), W'($urandom), $urandom_range(0, 1));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_24080006_stream_fifo.md
YSYX_24080006_STREAM_FIFO -- requirements
Module: ysyx_24080006_stream_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, entry count; any value >=2, power of two not required.
REQ-003 SHALL have parameter AF_LEVEL, default FIFO_DEPTH-1, usage at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 1, usage at or below which almost_empty asserts.
REQ-005 SHALL have parameter FALL_THROUGH, default 0, 1 enables the empty-bypass path.
REQ-006 SHALL derive localparam CNT_W = $clog2(FIFO_DEPTH+1).
REQ-007 clock  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 flush  input  1  synchronous clear of contents.
REQ-010 push_valid  input  1  producer offers push_data.
REQ-011 push_ready  output  1  FIFO can accept.
REQ-012 push_data  input  DATA_WIDTH  write payload.
REQ-013 pop_valid  output  1  pop_data valid.
REQ-014 pop_ready  input  1  consumer accepts.
REQ-015 pop_data  output  DATA_WIDTH  head payload.
REQ-016 usage  output  CNT_W  stored entries, 0..FIFO_DEPTH.
REQ-017 almost_full  output  1  usage >= AF_LEVEL.
REQ-018 almost_empty  output  1  usage <= AE_LEVEL.

Function
REQ-019 Push SHALL occur on a cycle with push_valid && push_ready; pop SHALL occur on a cycle with pop_valid && pop_ready.
REQ-020 push_ready SHALL be ~full && ~reset && ~flush; a push SHALL NOT be accepted when full, even with a simultaneous pop.
REQ-021 With FALL_THROUGH=0, pop_valid SHALL be (usage!=0) && ~flush, and pop_data SHALL be the oldest stored entry.
REQ-022 Read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0 for any FIFO_DEPTH, without using modulo.
REQ-023 Simultaneous push and pop with 0<usage<FIFO_DEPTH SHALL leave usage unchanged and advance both pointers.
REQ-024 A pushed word SHALL be poppable the next cycle: write-to-read latency of 1 cycle when FALL_THROUGH=0.
REQ-025 With FALL_THROUGH=1 and usage==0, pop_valid SHALL equal push_valid && ~flush, and pop_data SHALL equal push_data, combinationally.
REQ-026 With FALL_THROUGH=1, usage==0, and push and pop in the same cycle, the word SHALL bypass storage: pointers and usage unchanged.
REQ-027 With FALL_THROUGH=1, usage==0, and a push without pop, the word SHALL be stored normally.
REQ-028 With FALL_THROUGH=1 and usage>0, behaviour SHALL match FALL_THROUGH=0.
REQ-029 flush SHALL zero the pointers and usage at the next edge.
REQ-030 flush SHALL take priority over any push or pop in the same cycle; those handshakes are blocked.
REQ-031 Storage contents SHALL NOT be cleared by flush or reset; stale data SHALL never be presented with pop_valid=1.
REQ-032 almost_full, almost_empty and usage SHALL be registered or derived from registered state only, never from push_valid or pop_ready.
REQ-033 Storage SHALL be written only on an accepted push that is not a bypass.

Reset
REQ-034 While reset=1, and at the edge on which it is sampled, the block SHALL set pointers=0 and usage=0.
REQ-035 While reset=1, push_ready=0 and pop_valid=0.
REQ-036 After reset releases: usage=0, almost_empty=1, almost_full=0 (for AF_LEVEL>0), push_ready=1.
REQ-037 Reset asserted mid-transfer SHALL discard all contents; no handshake SHALL complete in a reset cycle.

Verification
REQ-038 DEPTH=3, W=8, FT=0: push 0x11,0x22,0x33 -> push_ready=0, usage=3, almost_full=1; pop three -> 0x11,0x22,0x33 in order, pop_valid=0.
REQ-039 DEPTH=3: sustain push and pop together for 10 cycles at usage=2 -> usage stays 2, data in order across pointer wrap 2->0.
REQ-040 FT=1, empty, push_valid=1, push_data=0xA5, pop_ready=1 -> pop_data=0xA5 same cycle, usage stays 0.
REQ-041 FT=1, empty, push 0x5A with pop_ready=0 -> usage=1 next cycle, pop_data=0x5A.
REQ-042 usage=2, flush=1 together with push_valid=1 and pop_ready=1 -> no handshake completes, usage=0 next cycle, pop_valid=0.
REQ-043 usage=2, reset pulsed for 1 cycle -> usage=0, pop_valid=0; next push 0x77 -> first pop returns 0x77.
